// File: rtl/bird_datapath.sv
// rtl/bird_datapath.sv - bird vertical position, status flags and per-frame erase/draw pixel sequencer
module bird_datapath #(
  parameter logic [7:0] BIRD_X      = 8'd40,
  parameter int         SIZE        = 4,
  parameter logic [6:0] Y_START     = 7'd56,
  parameter logic [6:0] GROUND_Y    = 7'd112,
  parameter int         RISE_STEP   = 2,
  parameter int         FALL_STEP   = 1,
  parameter int         RISE_HEIGHT = 16,
  parameter logic [2:0] BIRD_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] state_in,
  input  logic       frame_tick,
  input  logic       pipe_hit,
  output logic       flag,
  output logic       touched,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam int         CW         = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [6:0] Y_LOW      = GROUND_Y - 7'(SIZE);
  localparam logic [6:0] Y_FALL_MAX = Y_LOW - 7'(FALL_STEP);
  localparam logic [3:0] S_START    = 4'd0;
  localparam logic [3:0] S_RAISING  = 4'd1;
  localparam logic [3:0] S_FALLING  = 4'd2;
  localparam logic [3:0] S_DRAW     = 4'd4;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ERASE, SEQ_DRAW} seq_t;

  logic [6:0]        y, old_y, jump_base;
  logic [3:0]        phase;
  logic              jump_pending;
  seq_t              seq, seq_nxt;
  logic [CW-1:0]     cx, cy, cx_nxt, cy_nxt;
  logic              last_px, tick_ok;
  logic [6:0]        rise_y, fall_y, base_eff, row_base;
  logic signed [8:0] rise_lim;
  logic              rise_flag;

  // A tick arriving mid-sequence is dropped, not queued.
  assign tick_ok = frame_tick && (seq == SEQ_IDLE);

  always_comb begin
    rise_y    = (y >= 7'(RISE_STEP)) ? (y - 7'(RISE_STEP)) : 7'd0;
    fall_y    = (y >= Y_FALL_MAX) ? Y_LOW : (y + 7'(FALL_STEP));
    base_eff  = jump_pending ? y : jump_base;
    rise_lim  = $signed({2'b00, base_eff}) - $signed(9'(RISE_HEIGHT));
    rise_flag = ($signed({2'b00, rise_y}) <= rise_lim) || (rise_y == 7'd0);
  end

  always_comb begin
    seq_nxt = seq;
    cx_nxt  = cx;
    cy_nxt  = cy;
    last_px = (cx == CW'(SIZE - 1)) && (cy == CW'(SIZE - 1));
    case (seq)
      SEQ_IDLE: begin
        if (tick_ok) begin
          seq_nxt = SEQ_ERASE;
          cx_nxt  = '0;
          cy_nxt  = '0;
        end
      end
      default: begin
        if (cx == CW'(SIZE - 1)) begin
          cx_nxt = '0;
          cy_nxt = last_px ? '0 : (cy + CW'(1));
        end else begin
          cx_nxt = cx + CW'(1);
        end
        if (last_px) seq_nxt = (seq == SEQ_ERASE) ? SEQ_DRAW : SEQ_IDLE;
      end
    endcase
    row_base = (seq_nxt == SEQ_DRAW) ? y : old_y;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y            <= Y_START;
      old_y        <= Y_START;
      jump_base    <= Y_START;
      phase        <= S_START;
      jump_pending <= 1'b0;
      flag         <= 1'b0;
      touched      <= 1'b0;
      seq          <= SEQ_IDLE;
      cx           <= '0;
      cy           <= '0;
      vga_plot     <= 1'b0;
      busy         <= 1'b0;
      vga_x        <= 8'd0;
      vga_y        <= 7'd0;
      vga_colour   <= 3'd0;
    end else begin
      if (state_in != S_DRAW) begin
        phase <= state_in;
        if (state_in == S_RAISING && phase != S_RAISING) jump_pending <= 1'b1;
      end

      if (tick_ok) begin
        case (phase)
          S_START: begin
            y       <= Y_START;
            flag    <= 1'b0;
            touched <= 1'b0;
          end
          S_RAISING: begin
            y <= rise_y;
            if (jump_pending) begin
              jump_base    <= y;
              jump_pending <= 1'b0;
            end
            if (rise_flag) flag <= 1'b1;
            if (pipe_hit) touched <= 1'b1;
          end
          S_FALLING: begin
            y    <= fall_y;
            flag <= 1'b0;
            if (fall_y == Y_LOW || pipe_hit) touched <= 1'b1;
          end
          default: ;
        endcase
      end

      // Outputs carry the pixel selected by the next-state scan position.
      seq  <= seq_nxt;
      cx   <= cx_nxt;
      cy   <= cy_nxt;
      busy <= (seq_nxt != SEQ_IDLE);
      if (seq_nxt != SEQ_IDLE) begin
        vga_plot   <= 1'b1;
        vga_x      <= BIRD_X + 8'(cx_nxt);
        vga_y      <= row_base + 7'(cy_nxt);
        vga_colour <= (seq_nxt == SEQ_DRAW) ? BIRD_COLOUR : BG_COLOUR;
      end else begin
        vga_plot <= 1'b0;
      end
      if (seq == SEQ_DRAW && last_px) old_y <= y;
    end
  end

endmodule
